keypad_entry_buf: RTL
=====================

// Module: keypad_entry_buf
// PURPOSE
//  Parametrised keypad digit-entry buffer: turns raw pushbutton levels into
//  edge-detected edit events on an NDIG-digit, RADIX-limited display register.
//  Supports digit entry, backspace, clear, decimal point and circular rotation.
//  Sits between the board pushbuttons and the seven-segment decoder; its
//  digits/flt_pt outputs feed the decoder directly.
// PARAMETERS
//  NDIG         8   number of 4-bit digits held/displayed (2..8)
//  RADIX        16  accepted key range 0..RADIX-1 (2..16); keys >= RADIX ignored
//  SYNC_STAGES  2   synchroniser flops per button input (>=1)
// PORTS
//  hz100        in   1               system clock
//  reset        in   1               synchronous, active-high reset
//  pb           in   16              raw digit keys, bit i = key value i
//  shift_left   in   1               raw button: rotate digits left
//  shift_right  in   1               raw button: rotate digits right
//  backspace    in   1               raw button: delete digit 0
//  point        in   1               raw button: place decimal point on digit 0
//  clear        in   1               raw button: clear buffer
//  digits       out  NDIG*4          digit i in [4i+3:4i], digit 0 rightmost
//  flt_pt       out  NDIG            decimal point per digit, at most one set
//  count        out  $clog2(NDIG+1)  digits entered, 0..NDIG
//  overflow     out  1               sticky: a digit was lost off the left end
//  key_strobe   out  1               1-cycle pulse when an event is applied
// BEHAVIOUR
//  - Reset: digits=0, flt_pt=0, count=0, overflow=0, key_strobe=0; all
//    synchroniser and edge-history flops clear to 0. Reset beats every event.
//  - Each of the 21 inputs passes SYNC_STAGES flops, then a rising-edge detect
//    (sync output 1, previous 0). Level held high -> exactly one event.
//  - Latency: input first high at edge k -> state updated at edge
//    k+SYNC_STAGES+1; key_strobe high for the cycle following that update.
//  - One event applied per cycle. Priority: clear > backspace > digit >
//    point > shift_left > shift_right; lower-priority edges that cycle are
//    dropped. Several pb edges in one cycle: lowest index wins.
//  - clear: digits=0, flt_pt=0, count=0, overflow=0.
//  - digit v (v<RADIX): digits shift left one place, digit0=v; flt_pt shifts
//    left with it (bit NDIG-1 dropped); count=min(count+1,NDIG); if count was
//    NDIG, old digit NDIG-1 is lost and overflow sets. v>=RADIX: no event,
//    no strobe.
//  - backspace: digits shift right, digit NDIG-1=0; flt_pt shifts right (bit 0
//    dropped); count=max(count-1,0). At count=0: no state change, strobe fires.
//  - point: flt_pt = 1 (bit 0 only); any previous point is removed.
//  - shift_left / shift_right: circular rotate of digits and flt_pt by one
//    digit; count and overflow unchanged.
//  - Button held through reset: after reset deasserts it is seen as a new
//    press; event applies at edge SYNC_STAGES+1 after release of reset.
//  - Outputs are registered; no combinational path from inputs to outputs.
// TESTING
//  1 reset, press pb[3],pb[7],pb[1] one at a time -> digits[11:0]=0x371,
//    count=3, 3 single-cycle key_strobe pulses, overflow=0
//  2 RADIX=10: press pb[12] -> no change, no strobe; press pb[9] -> digit0=9
//  3 NDIG=8: 9 presses of pb[1]..pb[9] -> digits=0x23456789, count=8,
//    overflow=1; press clear -> all zero, overflow=0
//  4 enter 5,2; point; enter 6 -> digits=0x526, flt_pt=0b010; backspace x2 ->
//    digits=0x5, flt_pt=0, count=1; backspace x2 -> count=0, no underflow
//  5 digits=0x00000012, shift_right -> 0x20000001 with flt_pt rotating too;
//    shift_left restores 0x00000012; count unchanged
//  6 pb[4] and backspace rise same cycle -> backspace only; pb[2] held
//    through reset -> one digit-2 entry SYNC_STAGES+1 cycles after release

Source files
------------

// File: rtl/keypad_entry_buf.sv
// Keypad digit-entry buffer: synchronises raw buttons, detects rising edges and
// applies one prioritised edit event per cycle to an NDIG-digit display register.
module keypad_entry_buf #(
  parameter int NDIG        = 8,
  parameter int RADIX       = 16,
  parameter int SYNC_STAGES = 2,
  localparam int CW         = $clog2(NDIG + 1)
) (
  input  logic              hz100,
  input  logic              reset,
  input  logic [15:0]       pb,
  input  logic              shift_left,
  input  logic              shift_right,
  input  logic              backspace,
  input  logic              point,
  input  logic              clear,
  output logic [NDIG*4-1:0] digits,
  output logic [NDIG-1:0]   flt_pt,
  output logic [CW-1:0]     count,
  output logic              overflow,
  output logic              key_strobe
);

  localparam int NIN    = 21;
  localparam int IDX_SL = 16;
  localparam int IDX_SR = 17;
  localparam int IDX_PT = 18;
  localparam int IDX_BS = 19;
  localparam int IDX_CL = 20;

  logic [NIN-1:0] raw;
  logic [NIN-1:0] sync_reg [SYNC_STAGES];
  logic [NIN-1:0] prev_reg;
  logic [NIN-1:0] rise_reg;
  logic [15:0]    radix_mask;
  logic [15:0]    valid_key;
  logic [3:0]     key_val;

  logic [NDIG*4-1:0] digits_reg, digits_next;
  logic [NDIG-1:0]   flt_reg, flt_next;
  logic [CW-1:0]     count_reg, count_next;
  logic              ovf_reg, ovf_next;
  logic              strobe_reg, strobe_next;

  assign raw = {clear, backspace, point, shift_right, shift_left, pb};

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      always_ff @(posedge hz100) begin
        if (reset) begin
          sync_reg[gi] <= '0;
        end else if (gi == 0) begin
          sync_reg[gi] <= raw;
        end else begin
          sync_reg[gi] <= sync_reg[(gi > 0) ? gi - 1 : 0];
        end
      end
    end

    for (gi = 0; gi < 16; gi++) begin : g_radix
      assign radix_mask[gi] = (gi < RADIX);
    end
  endgenerate

  // Edges are registered once more so the edit stage sees a clean one-hot-ish vector.
  always_ff @(posedge hz100) begin
    if (reset) begin
      prev_reg <= '0;
      rise_reg <= '0;
    end else begin
      prev_reg <= sync_reg[SYNC_STAGES-1];
      rise_reg <= sync_reg[SYNC_STAGES-1] & ~prev_reg;
    end
  end

  assign valid_key = rise_reg[15:0] & radix_mask;

  always_comb begin
    key_val = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (valid_key[i]) key_val = 4'(i);
    end
  end

  always_comb begin
    digits_next = digits_reg;
    flt_next    = flt_reg;
    count_next  = count_reg;
    ovf_next    = ovf_reg;
    strobe_next = 1'b0;
    if (rise_reg[IDX_CL]) begin
      digits_next = '0;
      flt_next    = '0;
      count_next  = '0;
      ovf_next    = 1'b0;
      strobe_next = 1'b1;
    end else if (rise_reg[IDX_BS]) begin
      strobe_next = 1'b1;
      if (count_reg != '0) begin
        digits_next = {4'd0, digits_reg[NDIG*4-1:4]};
        flt_next    = {1'b0, flt_reg[NDIG-1:1]};
        count_next  = count_reg - 1'b1;
      end
    end else if (|valid_key) begin
      strobe_next = 1'b1;
      digits_next = {digits_reg[NDIG*4-5:0], key_val};
      flt_next    = {flt_reg[NDIG-2:0], 1'b0};
      if (count_reg == CW'(NDIG)) ovf_next = 1'b1;
      else                        count_next = count_reg + 1'b1;
    end else if (rise_reg[IDX_PT]) begin
      strobe_next = 1'b1;
      flt_next    = NDIG'(1);
    end else if (rise_reg[IDX_SL]) begin
      strobe_next = 1'b1;
      digits_next = {digits_reg[NDIG*4-5:0], digits_reg[NDIG*4-1:NDIG*4-4]};
      flt_next    = {flt_reg[NDIG-2:0], flt_reg[NDIG-1]};
    end else if (rise_reg[IDX_SR]) begin
      strobe_next = 1'b1;
      digits_next = {digits_reg[3:0], digits_reg[NDIG*4-1:4]};
      flt_next    = {flt_reg[0], flt_reg[NDIG-1:1]};
    end
  end

  always_ff @(posedge hz100) begin
    if (reset) begin
      digits_reg <= '0;
      flt_reg    <= '0;
      count_reg  <= '0;
      ovf_reg    <= 1'b0;
      strobe_reg <= 1'b0;
    end else begin
      digits_reg <= digits_next;
      flt_reg    <= flt_next;
      count_reg  <= count_next;
      ovf_reg    <= ovf_next;
      strobe_reg <= strobe_next;
    end
  end

  assign digits     = digits_reg;
  assign flt_pt     = flt_reg;
  assign count      = count_reg;
  assign overflow   = ovf_reg;
  assign key_strobe = strobe_reg;

endmodule
